// File: rtl/leaf_pe_ingress.sv
// leaf_pe_ingress: credit-managed ingress FIFO between one leaf-router output
// port and its processing element. Flits pushed by the router are buffered
// and handed to the PE. Each consumed flit returns one credit pulse upstream.
//
// Optional feature macro: LEAF_PE_INGRESS_BYPASS_EN
//   defined   -> a flit arriving at an empty buffer while the PE is ready is
//                delivered combinationally in the same cycle and never stored.
//   undefined -> every flit goes through the FIFO (one-cycle minimum latency,
//                no combinational input-to-output path).
//
// Handshake semantics (PE side): pe_valid/pe_data are offered whenever a flit
// is available. A transfer happens on a rising clock edge where both pe_valid
// and pe_ready are 1. pe_data stays stable while pe_valid=1 and pe_ready=0.
// Router side: in_data_valid is a push with no back-pressure. The router may
// push only while it holds a credit, and upstream_credit returns one credit
// per transfer, one cycle after it.

`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 8
`endif

module leaf_pe_ingress #(
    parameter int DATA_WIDTH = `ROUTER_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_data_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  upstream_credit,
    output logic                  pe_valid,
    output logic [DATA_WIDTH-1:0] pe_data,
    input  logic                  pe_ready,
    output logic [CNT_W-1:0]      occupancy,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    // Storage is not reset. Only the pointers and count define which entries are live.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;

    logic fifo_empty;
    logic fifo_full;
    logic bypass;
    logic pop;
    logic fifo_pop;
    logic fifo_push;
    logic push_dropped;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));

`ifdef LEAF_PE_INGRESS_BYPASS_EN
    // Cut-through only when nothing older is queued, so ordering is preserved.
    assign bypass = fifo_empty && in_data_valid && pe_ready;
`else
    assign bypass = 1'b0;
`endif

    // PE-facing head: either the cut-through flit or the FIFO head entry.
    always_comb begin
        pe_valid = !fifo_empty || bypass;
        pe_data  = bypass ? in_data : mem_q[rd_ptr_q];
    end

    // Transfer qualification. A bypassed flit counts as a pop for credit purposes
    // but touches neither pointers nor count. Push into a full FIFO is legal only
    // when the head leaves in the same cycle.
    always_comb begin
        pop          = pe_valid && pe_ready;
        fifo_pop     = pop && !bypass;
        fifo_push    = in_data_valid && !bypass && (!fifo_full || fifo_pop);
        push_dropped = in_data_valid && fifo_full && !fifo_pop;
    end

    // Next-state for pointers, occupancy, credit pulse and sticky overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = pop;
        overflow_d = overflow_q || push_dropped;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers. Reset discards all stored flits and any pending credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Flit storage write port.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign upstream_credit = credit_q;
    assign occupancy       = count_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_leaf_pe_ingress.sv
// tb_leaf_pe_ingress: directed scenarios plus randomized traffic for
// leaf_pe_ingress. It compares against a queue-based model of the buffer.
// Inputs change 1 time unit after each rising edge. Outputs are compared on
// the falling edge.

module tb_leaf_pe_ingress;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_data_valid;
  logic [W-1:0]     in_data;
  logic             upstream_credit;
  logic             pe_valid;
  logic [W-1:0]     pe_data;
  logic             pe_ready;
  logic [CNT_W-1:0] occupancy;
  logic             overflow;

  leaf_pe_ingress #(
    .DATA_WIDTH(W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data_valid(in_data_valid),
    .in_data(in_data),
    .upstream_credit(upstream_credit),
    .pe_valid(pe_valid),
    .pe_data(pe_data),
    .pe_ready(pe_ready),
    .occupancy(occupancy),
    .overflow(overflow)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The buffer is a queue of at most DEPTH flits. The credit pulse is
  // "a transfer happened at the last edge". Overflow is sticky.
  logic [W-1:0] exp_q[$];
  logic         m_credit;
  logic         m_overflow;

  initial begin
    exp_q.delete();
    m_credit   = 1'b0;
    m_overflow = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_credit   = 1'b0;
        m_overflow = 1'b0;
      end else begin
        int  sz;
        bit  take;
        bit  cut;
        sz   = exp_q.size();
        cut  = 1'b0;
`ifdef LEAF_PE_INGRESS_BYPASS_EN
        cut  = (sz == 0) && in_data_valid && pe_ready;
`endif
        take = ((sz > 0) && pe_ready) || cut;
        m_credit = take;
        if (!cut) begin
          if ((sz > 0) && pe_ready) void'(exp_q.pop_front());
          if (in_data_valid) begin
            if (sz < DEPTH || pe_ready) exp_q.push_back(in_data);
            else m_overflow = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [W-1:0] got_q[$];
  int           credit_cnt = 0;
  int           max_occ    = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic         ev;
        logic [W-1:0] ed;
        ev = (exp_q.size() > 0);
        ed = ev ? exp_q[0] : '0;
`ifdef LEAF_PE_INGRESS_BYPASS_EN
        if (!ev && in_data_valid && pe_ready) begin
          ev = 1'b1;
          ed = in_data;
        end
`endif
        check("pe_valid", 32'(pe_valid), 32'(ev));
        if (ev) check("pe_data", 32'(pe_data), 32'(ed));
        check("occupancy", 32'(occupancy), 32'(exp_q.size()));
        check("upstream_credit", 32'(upstream_credit), 32'(m_credit));
        check("overflow", 32'(overflow), 32'(m_overflow));
        if (pe_valid && pe_ready) got_q.push_back(pe_data);
        if (upstream_credit) credit_cnt++;
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    in_data_valid = 1'b1;
    in_data       = d;
    tick();
    in_data_valid = 1'b0;
  endtask

  task automatic clear_obs();
    got_q.delete();
    credit_cnt = 0;
    max_occ    = 0;
  endtask

  // Observed deliveries must equal base, base+1, ... (n flits).
  task automatic check_seq(input string name, input logic [W-1:0] base, input int n);
    check({name, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check(name, 32'(got_q[i]), 32'(base + W'(i)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    in_data_valid = 1'b0;
    in_data       = '0;
    pe_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("reset_occupancy", 32'(occupancy), 32'd0);
    check("reset_pe_valid", 32'(pe_valid), 32'd0);
    check("reset_credit", 32'(upstream_credit), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    tick();

    // Fill with PE stalled, then drain.
    clear_obs();
    for (int i = 0; i < DEPTH; i++) push(W'(8'hA0 + i));
    @(negedge clk);
    check("fill_occupancy", 32'(occupancy), 32'd4);
    check("fill_no_credit", 32'(credit_cnt), 32'd0);
    tick();
    pe_ready = 1'b1;
    repeat (4) tick();
    pe_ready = 1'b0;
    repeat (2) tick();
    check_seq("drain_data", 8'hA0, 4);
    check("drain_credits", 32'(credit_cnt), 32'd4);

    // Streaming across the pointer wrap.
    clear_obs();
    pe_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(W'(i));
    repeat (3) tick();
    pe_ready = 1'b0;
    tick();
    check_seq("stream_data", 8'h00, 10);
    check("stream_credits", 32'(credit_cnt), 32'd10);
    check("stream_max_occ_le1", 32'(max_occ <= 1), 32'd1);

    // Push into a full FIFO while popping.
    clear_obs();
    for (int i = 0; i < DEPTH; i++) push(W'(8'hB0 + i));
    pe_ready = 1'b1;
    push(8'hFF);
    pe_ready = 1'b0;
    @(negedge clk);
    check("fullpp_occupancy", 32'(occupancy), 32'd4);
    check("fullpp_overflow", 32'(overflow), 32'd0);
    tick();
    pe_ready = 1'b1;
    repeat (5) tick();
    pe_ready = 1'b0;
    tick();
    check("fullpp_count", 32'(got_q.size()), 32'd5);
    if (got_q.size() == 5) begin
      check("fullpp_d0", 32'(got_q[0]), 32'hB0);
      check("fullpp_d3", 32'(got_q[3]), 32'hB3);
      check("fullpp_d4", 32'(got_q[4]), 32'hFF);
    end

    // Overflow: push into a full FIFO with the PE stalled.
    clear_obs();
    for (int i = 0; i < DEPTH; i++) push(W'(8'hC0 + i));
    push(8'hEE);
    @(negedge clk);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_occupancy", 32'(occupancy), 32'd4);
    tick();
    pe_ready = 1'b1;
    repeat (6) tick();
    pe_ready = 1'b0;
    tick();
    check_seq("ovf_drain", 8'hC0, 4);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset with three flits stored.
    for (int i = 0; i < 3; i++) push(W'(8'hD0 + i));
    #2 rst_n = 1'b0;
    #1;
    check("arst_pe_valid", 32'(pe_valid), 32'd0);
    check("arst_credit", 32'(upstream_credit), 32'd0);
    check("arst_occupancy", 32'(occupancy), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_occupancy", 32'(occupancy), 32'd0);
    check("post_rst_pe_valid", 32'(pe_valid), 32'd0);
    tick();

`ifdef LEAF_PE_INGRESS_BYPASS_EN
    // Cut-through on an empty buffer.
    clear_obs();
    pe_ready      = 1'b1;
    in_data_valid = 1'b1;
    in_data       = 8'h5A;
    @(negedge clk);
    check("byp_pe_valid", 32'(pe_valid), 32'd1);
    check("byp_pe_data", 32'(pe_data), 32'h5A);
    check("byp_occupancy", 32'(occupancy), 32'd0);
    tick();
    in_data_valid = 1'b0;
    pe_ready      = 1'b0;
    @(negedge clk);
    check("byp_credit", 32'(upstream_credit), 32'd1);
    check("byp_occ_after", 32'(occupancy), 32'd0);
    tick();
`endif

    // Randomized traffic in phases of differing push/ready pressure.
    for (int ph = 0; ph < 4; ph++) begin
      int push_pct;
      int ready_pct;
      push_pct  = int'($urandom_range(20, 90));
      ready_pct = int'($urandom_range(20, 90));
      for (int c = 0; c < 150; c++) begin
        in_data_valid = ($urandom_range(0, 99) < push_pct);
        in_data       = W'($urandom_range(0, 255));
        pe_ready      = ($urandom_range(0, 99) < ready_pct);
        tick();
      end
    end
    in_data_valid = 1'b0;
    pe_ready      = 1'b1;
    repeat (DEPTH + 2) tick();
    pe_ready = 1'b0;
    @(negedge clk);
    check("final_occupancy", 32'(occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
